// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, decode result, execute payload and the decoder.
package pipe_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef struct packed {
    logic             src1_used;
    logic             src2_used;
    logic [REG_W-1:0] dest;
    logic             dest_valid;
  } decode_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  dest;
    logic              dest_valid;
  } ex_payload_t;

  // Unlisted opcodes decode as I-type (rs source, rt dest); r0 is never a real dest.
  function automatic decode_t decode_instr(input logic [DATA_W-1:0] instr);
    decode_t d;
    d.src1_used  = 1'b1;
    d.src2_used  = 1'b0;
    d.dest       = instr[20:16];
    d.dest_valid = 1'b1;
    case (instr[31:26])
      OP_RTYPE: begin
        d.src2_used = 1'b1;
        d.dest      = instr[15:11];
      end
      OP_LW: d.src2_used = 1'b0;
      OP_SW, OP_BEQ, OP_BNE: begin
        d.src2_used  = 1'b1;
        d.dest       = '0;
        d.dest_valid = 1'b0;
      end
      OP_J: begin
        d.src1_used  = 1'b0;
        d.dest       = '0;
        d.dest_valid = 1'b0;
      end
      OP_JAL: begin
        d.src1_used = 1'b0;
        d.dest      = REG_W'(31);
      end
      default: ;
    endcase
    if (d.dest == '0) d.dest_valid = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue, cleared on writeback.
module reg_scoreboard
  import pipe_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_reg_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_reg_i,
  input  logic [REG_W-1:0] src1_reg_i,
  input  logic [REG_W-1:0] src2_reg_i,
  input  logic [REG_W-1:0] dest_reg_i,
  output logic             src1_pending_o,
  output logic             src2_pending_o,
  output logic             dest_pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_reg_i] = 1'b0;
    if (set_en_i) pending_d[set_reg_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign src1_pending_o = pending_q[src1_reg_i];
  assign src2_pending_o = pending_q[src2_reg_i];
  assign dest_pending_o = pending_q[dest_reg_i];

endmodule

// File: rtl/operand_issue.sv
// Decode/operand-issue stage: holds one instruction, stalls on RAW/WAW hazards,
// and captures register-file operands into the execute-facing output register.
module operand_issue
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic [4:0]       rf_read_reg_1,
  output logic [4:0]       rf_read_reg_2,
  input  logic [WIDTH-1:0] rf_read_data_1,
  input  logic [WIDTH-1:0] rf_read_data_2,
  input  logic [4:0]       wb_write_reg,
  input  logic             wb_write_enable,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] ex_instr,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_op_a,
  output logic [WIDTH-1:0] ex_op_b,
  output logic [4:0]       ex_dest,
  output logic             ex_dest_valid
);

  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_instr_q, d_instr_d;
  logic [DATA_W-1:0] d_pc_q, d_pc_d;
  logic              ex_valid_q, ex_valid_d;
  ex_payload_t       ex_q, ex_d;

  decode_t dec;
  logic    src1_pend, src2_pend, dest_pend;
  logic    hazard, issue, accept;

  assign dec           = decode_instr(d_instr_q);
  assign rf_read_reg_1 = d_instr_q[25:21];
  assign rf_read_reg_2 = d_instr_q[20:16];

  reg_scoreboard u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .set_en_i       (issue & dec.dest_valid),
    .set_reg_i      (dec.dest),
    .clr_en_i       (wb_write_enable),
    .clr_reg_i      (wb_write_reg),
    .src1_reg_i     (rf_read_reg_1),
    .src2_reg_i     (rf_read_reg_2),
    .dest_reg_i     (dec.dest),
    .src1_pending_o (src1_pend),
    .src2_pending_o (src2_pend),
    .dest_pending_o (dest_pend)
  );

  // Flush suppresses issue entirely, so a redirected instruction never marks the scoreboard.
  assign hazard   = (dec.src1_used & src1_pend) | (dec.src2_used & src2_pend)
                  | (dec.dest_valid & dest_pend);
  assign issue    = d_valid_q & ~hazard & (~ex_valid_q | ex_ready) & ~flush;
  assign in_ready = ~flush & (~d_valid_q | issue);
  assign accept   = in_valid & in_ready;

  always_comb begin
    d_valid_d  = d_valid_q;
    d_instr_d  = d_instr_q;
    d_pc_d     = d_pc_q;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;

    if (flush) begin
      d_valid_d = 1'b0;
    end else if (accept) begin
      d_valid_d = 1'b1;
      d_instr_d = in_instr;
      d_pc_d    = in_pc;
    end else if (issue) begin
      d_valid_d = 1'b0;
    end

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d       = 1'b1;
      ex_d.instr       = d_instr_q;
      ex_d.pc          = d_pc_q;
      ex_d.op_a        = rf_read_data_1;
      ex_d.op_b        = rf_read_data_2;
      ex_d.dest        = dec.dest;
      ex_d.dest_valid  = dec.dest_valid;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_q  <= 1'b0;
      d_instr_q  <= '0;
      d_pc_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_instr_q  <= d_instr_d;
      d_pc_q     <= d_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_instr      = ex_q.instr;
  assign ex_pc         = ex_q.pc;
  assign ex_op_a       = ex_q.op_a;
  assign ex_op_b       = ex_q.op_b;
  assign ex_dest       = ex_q.dest;
  assign ex_dest_valid = ex_q.dest_valid;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios plus random traffic, checked against a
// transaction-level model of the stage, its scoreboard set, and a behavioural register file.
module tb_operand_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_read_reg_1, rf_read_reg_2;
  logic [31:0] rf_read_data_1, rf_read_data_2;
  logic [4:0]  wb_write_reg;
  logic        wb_write_enable;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_instr, ex_pc, ex_op_a, ex_op_b;
  logic [4:0]  ex_dest;
  logic        ex_dest_valid;

  always #5 clock = ~clock;

  operand_issue #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_write_reg(wb_write_reg), .wb_write_enable(wb_write_enable), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_dest(ex_dest), .ex_dest_valid(ex_dest_valid)
  );

  // Register file: written on rising edge, read addresses sampled on falling edge.
  logic [31:0] rf [32];
  logic [31:0] wb_data;
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 + 32'(i);
    end else if (wb_write_enable) begin
      rf[wb_write_reg] <= wb_data;
    end
  end
  always @(negedge clock) begin
    rf_read_data_1 <= rf[rf_read_reg_1];
    rf_read_data_2 <= rf[rf_read_reg_2];
  end

  // Reference model state
  bit          m_dv, m_xv, m_xdv;
  logic [31:0] m_di, m_dp, m_xi, m_xp, m_xa, m_xb;
  logic [4:0]  m_xd;
  bit          m_pend [32];
  logic [31:0] pc_ctr;
  int          n_pass, n_checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Source registers as a bitmask (r0 never counts) and destination as -1 when absent.
  function automatic void m_dec(input logic [31:0] ins, output logic [31:0] srcs, output int dst);
    int rs, rt, rd;
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    case (ins[31:26])
      6'h00:               begin srcs = (32'd1 << rs) | (32'd1 << rt); dst = rd; end
      6'h2b, 6'h04, 6'h05: begin srcs = (32'd1 << rs) | (32'd1 << rt); dst = -1; end
      6'h02:               begin srcs = 32'd0; dst = -1; end
      6'h03:               begin srcs = 32'd0; dst = 31; end
      default:             begin srcs = 32'd1 << rs; dst = rt; end
    endcase
    srcs[0] = 1'b0;
    if (dst == 0) dst = -1;
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    ex_ready = 1'b0; wb_write_enable = 1'b0; wb_write_reg = '0; wb_data = '0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    m_dv = 0; m_xv = 0; m_xdv = 0; m_di = '0; m_dp = '0;
    m_xi = '0; m_xp = '0; m_xa = '0; m_xb = '0; m_xd = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_dest_valid", 32'(ex_dest_valid), 32'd0);
    chk("rst_ex_instr", ex_instr, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_op_a", ex_op_a, 32'd0);
    chk("rst_ex_op_b", ex_op_b, 32'd0);
    chk("rst_ex_dest", 32'(ex_dest), 32'd0);
    chk("rst_rf_reg_1", 32'(rf_read_reg_1), 32'd0);
    chk("rst_rf_reg_2", 32'(rf_read_reg_2), 32'd0);
    chk("rst_pending", dut.u_scoreboard.pending_q, 32'd0);
  endtask

  // One clock: drive inputs, check outputs against the model, then advance model and DUT.
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit rdy, input bit wbe,
                       input logic [4:0] wbr, input logic [31:0] wbd, input bit fl);
    logic [31:0] srcs;
    int          dst;
    bit          haz, iss, exp_rdy;
    in_valid = iv; in_instr = ins; in_pc = pc_ctr; ex_ready = rdy;
    wb_write_enable = wbe; wb_write_reg = wbr; wb_data = wbd; flush = fl;
    #1;
    m_dec(m_di, srcs, dst);
    haz     = ((srcs & pend_vec()) != 32'd0) || (dst >= 0 && m_pend[dst]);
    iss     = m_dv && !haz && (!m_xv || rdy) && !fl;
    exp_rdy = !fl && (!m_dv || iss);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("ex_valid", 32'(ex_valid), 32'(m_xv));
    if (m_xv) begin
      chk("ex_instr", ex_instr, m_xi);
      chk("ex_pc", ex_pc, m_xp);
      chk("ex_op_a", ex_op_a, m_xa);
      chk("ex_op_b", ex_op_b, m_xb);
      chk("ex_dest", 32'(ex_dest), 32'(m_xd));
      chk("ex_dest_valid", 32'(ex_dest_valid), 32'(m_xdv));
    end
    if (m_dv) begin
      chk("rf_read_reg_1", 32'(rf_read_reg_1), 32'(m_di[25:21]));
      chk("rf_read_reg_2", 32'(rf_read_reg_2), 32'(m_di[20:16]));
    end
    chk("pending", dut.u_scoreboard.pending_q, pend_vec());

    if (wbe) m_pend[wbr] = 0;
    if (fl) begin
      m_xv = 0;
    end else if (iss) begin
      m_xv  = 1;
      m_xi  = m_di;
      m_xp  = m_dp;
      m_xa  = rf[m_di[25:21]];
      m_xb  = rf[m_di[20:16]];
      m_xdv = (dst >= 0);
      m_xd  = (dst >= 0) ? 5'(dst) : 5'd0;
      if (dst >= 0) m_pend[dst] = 1;
    end else if (rdy) begin
      m_xv = 0;
    end
    if (fl) begin
      m_dv = 0;
    end else if (iv && exp_rdy) begin
      m_dv = 1; m_di = ins; m_dp = pc_ctr;
    end else if (iss) begin
      m_dv = 0;
    end
    if (iv && exp_rdy) pc_ctr = pc_ctr + 32'd4;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 32'd0, rdy, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic send(input logic [31:0] ins, input bit rdy);
    cycle(1'b1, ins, rdy, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  logic [31:0] snap, ins, wd;
  logic [5:0]  ops [8];
  int          cnt;
  bit          wbe_r, fl_r;
  logic [4:0]  wbr_r;
  int          cand [$];

  initial begin
    n_pass = 0; n_checks = 0; pc_ctr = 32'h0000_1000;
    ops = '{6'h00, 6'h23, 6'h08, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
    do_reset(2);

    // Four independent adds stream back to back
    cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      send(r_ins(5'd0, 5'd0, 5'(i), 6'h20), 1'b1);
      if (ex_valid === 1'b1) cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      if (ex_valid === 1'b1) cnt++;
    end
    chk("stream_valid_cycles", 32'(cnt), 32'd4);
    chk("stream_pending", dut.u_scoreboard.pending_q, 32'h0000_001E);

    // RAW on r5 resolved by writeback of 0x1234
    send(r_ins(5'd0, 5'd0, 5'd5, 6'h20), 1'b1);
    send(r_ins(5'd5, 5'd0, 5'd6, 6'h22), 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("raw_in_ready", 32'(in_ready), 32'd0);
    chk("raw_rf_reg_1", 32'(rf_read_reg_1), 32'd5);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
    chk("raw_not_yet", 32'(ex_valid), 32'd0);
    idle(1'b1);
    chk("raw_issue_valid", 32'(ex_valid), 32'd1);
    chk("raw_issue_instr", ex_instr, r_ins(5'd5, 5'd0, 5'd6, 6'h22));
    chk("raw_op_a", ex_op_a, 32'h0000_1234);

    // Writeback and issue hit r7 together: set wins
    send(r_ins(5'd0, 5'd0, 5'd7, 6'h20), 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0077, 1'b0);
    chk("set_wins_r7", 32'(dut.u_scoreboard.pending_q[7]), 32'd1);

    // WAW: second lw r8 waits for the first one's writeback
    send(i_ins(6'h23, 5'd0, 5'd8, 16'h0010), 1'b1);
    send(i_ins(6'h23, 5'd0, 5'd8, 16'h0020), 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("waw_stall_in_ready", 32'(in_ready), 32'd0);
    chk("waw_first_instr", ex_instr, i_ins(6'h23, 5'd0, 5'd8, 16'h0010));
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd8, 32'h0000_0088, 1'b0);
    idle(1'b1);
    chk("waw_second_instr", ex_instr, i_ins(6'h23, 5'd0, 5'd8, 16'h0020));
    chk("waw_pend8", 32'(dut.u_scoreboard.pending_q[8]), 32'd1);

    // Backpressure: ex_ready low three cycles
    send(r_ins(5'd0, 5'd0, 5'd9, 6'h20), 1'b1);
    send(r_ins(5'd0, 5'd0, 5'd10, 6'h20), 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(r_ins(5'd0, 5'd0, 5'd11, 6'h20), 1'b0);
      chk("bp_instr", ex_instr, r_ins(5'd0, 5'd0, 5'd9, 6'h20));
      chk("bp_dest", 32'(ex_dest), 32'd9);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    idle(1'b1);
    idle(1'b1);

    // Flush while stalled on r7 and with ex_valid held
    send(r_ins(5'd0, 5'd0, 5'd12, 6'h20), 1'b0);
    send(r_ins(5'd7, 5'd0, 5'd13, 6'h20), 1'b0);
    idle(1'b0);
    snap = pend_vec();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_pending", dut.u_scoreboard.pending_q, snap);
    send(r_ins(5'd0, 5'd0, 5'd14, 6'h20), 1'b1);
    idle(1'b1);
    chk("post_flush_issue", ex_instr, r_ins(5'd0, 5'd0, 5'd14, 6'h20));

    // Reset while stalled drops the held instruction
    send(r_ins(5'd7, 5'd7, 5'd15, 6'h20), 1'b1);
    idle(1'b1);
    do_reset(1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ins        = $urandom;
      ins[31:26] = ops[$urandom_range(0, 7)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
      wbe_r = 1'b0;
      wbr_r = 5'($urandom_range(0, 31));
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        wbe_r = 1'b1;
        wbr_r = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      wd   = $urandom;
      fl_r = ($urandom_range(0, 19) == 0);
      cycle(($urandom_range(0, 9) < 7), ins, ($urandom_range(0, 9) < 7), wbe_r, wbr_r, wd, fl_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
